rs_alu_station: RTL
===================

Name: rs_alu_station

Overview:
Reservation station for the integer execution path of the out-of-order RISC-V core; sits directly upstream of the ALU.
- Accepts decoded ALU/branch/jump/LUI/AUIPC ops from the dispatcher, each with operand values or pending ROB tags.
- Snoops the ALU and LSB result broadcasts to wake waiting operands.
- Sends at most one ready op per cycle to the ALU as a registered, one-cycle pulse bundle.

Parameters:
RS_SIZE, 16, number of entries (power of two)
ROB_POS_W, 4, ROB tag width
DATA_W, 32, operand/immediate/PC width

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global ready; when low, all state frozen
rollback  in  1  misprediction flush
full  out  1  no free entry; dispatcher must not issue while high
issue_en  in  1  new op valid this cycle
issue_rob_pos  in  ROB_POS_W  destination ROB tag
issue_opcode  in  7  opcode
issue_funct3  in  3  funct3
issue_funct7  in  1  funct7 bit 5
issue_val1  in  DATA_W  rs1 value (valid when issue_q1_busy=0)
issue_q1_busy  in  1  rs1 pending
issue_q1  in  ROB_POS_W  rs1 producer tag
issue_val2  in  DATA_W  rs2 value (valid when issue_q2_busy=0)
issue_q2_busy  in  1  rs2 pending
issue_q2  in  ROB_POS_W  rs2 producer tag
issue_imm  in  DATA_W  immediate
issue_pc  in  DATA_W  instruction PC
alu_res_en  in  1  ALU broadcast valid
alu_res_rob_pos  in  ROB_POS_W  ALU broadcast tag
alu_res_val  in  DATA_W  ALU broadcast value
lsb_res_en  in  1  LSB broadcast valid
lsb_res_rob_pos  in  ROB_POS_W  LSB broadcast tag
lsb_res_val  in  DATA_W  LSB broadcast value
alu_en  out  1  op valid to ALU (single-cycle pulse per op)
alu_rob_pos, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_pc  out  matching widths  op fields to ALU

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. rst clears all entry busy bits. All alu_* outputs reset to 0.
- Rollback: clears all busy bits and drives alu_en to 0 at the next edge. Issue and broadcasts presented in that same cycle are discarded. Rollback is evaluated when rdy is high; rst is evaluated regardless of rdy.
- rdy=0: no state or output changes. alu_en holds its value, and the ALU gates on rdy.
- Entry state: busy, opcode, funct3, funct7, rob_pos, imm, pc, val1/q1_busy/q1, val2/q2_busy/q2.
- full (combinational from registered busy bits): high iff all RS_SIZE entries are busy. An entry freed by dispatch in cycle N is free for issue from cycle N+1.
- Issue: on issue_en, write the lowest-indexed non-busy entry and set its busy bit.
- Issue-cycle forwarding: if an issued operand is pending and its tag matches a valid broadcast in the same cycle, store the broadcast value with busy cleared.
- Wakeup: for every busy entry, a pending operand whose tag equals alu_res_rob_pos (when alu_res_en) or lsb_res_rob_pos (when lsb_res_en) captures that value and clears its pending flag.
- Broadcast tags are distinct by ROB construction. If both broadcasts ever carry the same tag, the ALU value is taken.
- Select: the lowest-indexed entry that is busy with both operands not pending, using registered state (pre-edge).
  - At the edge: selected fields go to alu_*, alu_en<=1, and the entry is freed.
  - If no entry is ready: alu_en<=0; other alu_* outputs hold.
- Latency:
  - Op issued ready in cycle N: alu_en high in cycle N+2.
  - Op woken by a broadcast in cycle N: alu_en high in cycle N+2 at the earliest.
- Throughput: one dispatch per cycle. Issue and dispatch may occur in the same cycle, including an issue of a new op while a different entry dispatches.
- An entry is never dispatched twice.
- Operands of ops that do not use rs2 arrive as not pending (dispatcher responsibility). The station does not inspect opcode for readiness.

Test Plan:
1. Reset, then issue ADD rob=3, val1=5, val2=7, both ready, at cycle 1 → alu_en=1 in cycle 3 only with rob_pos=3, val1=5, val2=7; full=0 throughout.
2. Issue rob=2 with q1 pending on tag 6; alu_res_en tag 6 val 0x10 two cycles later → dispatch two cycles after the broadcast with val1=0x10; no dispatch before it.
3. Issue with q2 pending on tag 9 in the same cycle as lsb_res_en tag 9 val 0xAB → stored ready; dispatch 2 cycles later with val2=0xAB.
4. Fill 16 waiting entries → full=1. Wake entry 4 → after its dispatch, full=0 next cycle. The next issue lands in entry 4 (lowest free).
5. Several waiting entries, rollback asserted in the same cycle as an issue and a broadcast → next cycle all entries free, alu_en=0, full=0. The issued op never dispatches.
6. Two ready entries (indices 1, 5), rdy low for 3 cycles → no output change while low. After rdy rises: entry 1 then entry 5 dispatch on consecutive cycles.

Source files
------------

// File: rtl/rs_alu_station_if.sv
// Bundle between dispatcher / result buses and the ALU reservation station.
// The slave modport is the station's view; the master modport is everything around it.
interface rs_alu_station_if #(
    parameter int ROB_POS_W = 4,
    parameter int DATA_W    = 32
);
    logic                 rdy;
    logic                 rollback;
    logic                 full;

    logic                 issue_en;
    logic [ROB_POS_W-1:0] issue_rob_pos;
    logic [6:0]           issue_opcode;
    logic [2:0]           issue_funct3;
    logic                 issue_funct7;
    logic [DATA_W-1:0]    issue_val1;
    logic                 issue_q1_busy;
    logic [ROB_POS_W-1:0] issue_q1;
    logic [DATA_W-1:0]    issue_val2;
    logic                 issue_q2_busy;
    logic [ROB_POS_W-1:0] issue_q2;
    logic [DATA_W-1:0]    issue_imm;
    logic [DATA_W-1:0]    issue_pc;

    logic                 alu_res_en;
    logic [ROB_POS_W-1:0] alu_res_rob_pos;
    logic [DATA_W-1:0]    alu_res_val;
    logic                 lsb_res_en;
    logic [ROB_POS_W-1:0] lsb_res_rob_pos;
    logic [DATA_W-1:0]    lsb_res_val;

    logic                 alu_en;
    logic [ROB_POS_W-1:0] alu_rob_pos;
    logic [6:0]           alu_opcode;
    logic [2:0]           alu_funct3;
    logic                 alu_funct7;
    logic [DATA_W-1:0]    alu_val1;
    logic [DATA_W-1:0]    alu_val2;
    logic [DATA_W-1:0]    alu_imm;
    logic [DATA_W-1:0]    alu_pc;

    modport slave (
        input  rdy, rollback,
        input  issue_en, issue_rob_pos, issue_opcode, issue_funct3, issue_funct7,
        input  issue_val1, issue_q1_busy, issue_q1, issue_val2, issue_q2_busy, issue_q2,
        input  issue_imm, issue_pc,
        input  alu_res_en, alu_res_rob_pos, alu_res_val,
        input  lsb_res_en, lsb_res_rob_pos, lsb_res_val,
        output full,
        output alu_en, alu_rob_pos, alu_opcode, alu_funct3, alu_funct7,
        output alu_val1, alu_val2, alu_imm, alu_pc
    );

    modport master (
        output rdy, rollback,
        output issue_en, issue_rob_pos, issue_opcode, issue_funct3, issue_funct7,
        output issue_val1, issue_q1_busy, issue_q1, issue_val2, issue_q2_busy, issue_q2,
        output issue_imm, issue_pc,
        output alu_res_en, alu_res_rob_pos, alu_res_val,
        output lsb_res_en, lsb_res_rob_pos, lsb_res_val,
        input  full,
        input  alu_en, alu_rob_pos, alu_opcode, alu_funct3, alu_funct7,
        input  alu_val1, alu_val2, alu_imm, alu_pc
    );
endinterface

// File: rtl/rs_alu_station.sv
// Reservation station for the integer ALU path: holds dispatched ops until both
// operands are available, snoops ALU/LSB result broadcasts, and hands at most one
// ready op per cycle to the ALU as a registered single-cycle pulse.
module rs_alu_station #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_POS_W = 4,
    parameter int DATA_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    rs_alu_station_if.slave    bus
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]   busy;
    logic [RS_SIZE-1:0]   q1_busy;
    logic [RS_SIZE-1:0]   q2_busy;
    logic [ROB_POS_W-1:0] q1      [RS_SIZE];
    logic [ROB_POS_W-1:0] q2      [RS_SIZE];
    logic [DATA_W-1:0]    val1    [RS_SIZE];
    logic [DATA_W-1:0]    val2    [RS_SIZE];
    logic [ROB_POS_W-1:0] rob_pos [RS_SIZE];
    logic [6:0]           opcode  [RS_SIZE];
    logic [2:0]           funct3  [RS_SIZE];
    logic                 funct7  [RS_SIZE];
    logic [DATA_W-1:0]    imm     [RS_SIZE];
    logic [DATA_W-1:0]    pc      [RS_SIZE];

    logic [RS_SIZE-1:0] ready_vec;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic               free_valid;
    logic [IDX_W-1:0]   free_idx;

    assign ready_vec = busy & ~q1_busy & ~q2_busy;
    assign bus.full  = &busy;

    // Priority encoders: lowest ready entry for dispatch, lowest free entry for issue.
    always_comb begin
        sel_valid  = 1'b0;
        sel_idx    = '0;
        free_valid = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!busy[i]) begin
                free_valid = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Entry storage, operand wakeup, issue with forwarding, and dispatch to the ALU.
    // Within each wakeup the ALU match is written last so it wins on a tag collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy            <= '0;
            bus.alu_en      <= 1'b0;
            bus.alu_rob_pos <= '0;
            bus.alu_opcode  <= '0;
            bus.alu_funct3  <= '0;
            bus.alu_funct7  <= 1'b0;
            bus.alu_val1    <= '0;
            bus.alu_val2    <= '0;
            bus.alu_imm     <= '0;
            bus.alu_pc      <= '0;
        end else if (bus.rdy) begin
            if (bus.rollback) begin
                busy       <= '0;
                bus.alu_en <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i]) begin
                        if (q1_busy[i] && bus.lsb_res_en && q1[i] == bus.lsb_res_rob_pos) begin
                            val1[i]    <= bus.lsb_res_val;
                            q1_busy[i] <= 1'b0;
                        end
                        if (q1_busy[i] && bus.alu_res_en && q1[i] == bus.alu_res_rob_pos) begin
                            val1[i]    <= bus.alu_res_val;
                            q1_busy[i] <= 1'b0;
                        end
                        if (q2_busy[i] && bus.lsb_res_en && q2[i] == bus.lsb_res_rob_pos) begin
                            val2[i]    <= bus.lsb_res_val;
                            q2_busy[i] <= 1'b0;
                        end
                        if (q2_busy[i] && bus.alu_res_en && q2[i] == bus.alu_res_rob_pos) begin
                            val2[i]    <= bus.alu_res_val;
                            q2_busy[i] <= 1'b0;
                        end
                    end
                end

                if (bus.issue_en && free_valid) begin
                    busy[free_idx]    <= 1'b1;
                    rob_pos[free_idx] <= bus.issue_rob_pos;
                    opcode[free_idx]  <= bus.issue_opcode;
                    funct3[free_idx]  <= bus.issue_funct3;
                    funct7[free_idx]  <= bus.issue_funct7;
                    imm[free_idx]     <= bus.issue_imm;
                    pc[free_idx]      <= bus.issue_pc;
                    q1[free_idx]      <= bus.issue_q1;
                    q2[free_idx]      <= bus.issue_q2;
                    val1[free_idx]    <= bus.issue_val1;
                    q1_busy[free_idx] <= bus.issue_q1_busy;
                    val2[free_idx]    <= bus.issue_val2;
                    q2_busy[free_idx] <= bus.issue_q2_busy;
                    if (bus.issue_q1_busy && bus.lsb_res_en && bus.issue_q1 == bus.lsb_res_rob_pos) begin
                        val1[free_idx]    <= bus.lsb_res_val;
                        q1_busy[free_idx] <= 1'b0;
                    end
                    if (bus.issue_q1_busy && bus.alu_res_en && bus.issue_q1 == bus.alu_res_rob_pos) begin
                        val1[free_idx]    <= bus.alu_res_val;
                        q1_busy[free_idx] <= 1'b0;
                    end
                    if (bus.issue_q2_busy && bus.lsb_res_en && bus.issue_q2 == bus.lsb_res_rob_pos) begin
                        val2[free_idx]    <= bus.lsb_res_val;
                        q2_busy[free_idx] <= 1'b0;
                    end
                    if (bus.issue_q2_busy && bus.alu_res_en && bus.issue_q2 == bus.alu_res_rob_pos) begin
                        val2[free_idx]    <= bus.alu_res_val;
                        q2_busy[free_idx] <= 1'b0;
                    end
                end

                // The selected entry is busy, so it can never be the entry being issued into.
                if (sel_valid) begin
                    busy[sel_idx]   <= 1'b0;
                    bus.alu_en      <= 1'b1;
                    bus.alu_rob_pos <= rob_pos[sel_idx];
                    bus.alu_opcode  <= opcode[sel_idx];
                    bus.alu_funct3  <= funct3[sel_idx];
                    bus.alu_funct7  <= funct7[sel_idx];
                    bus.alu_val1    <= val1[sel_idx];
                    bus.alu_val2    <= val2[sel_idx];
                    bus.alu_imm     <= imm[sel_idx];
                    bus.alu_pc      <= pc[sel_idx];
                end else begin
                    bus.alu_en <= 1'b0;
                end
            end
        end
    end
endmodule
